// File: rtl/operate_sequencer.sv
// LC-3 operate-instruction sequencer: accepts ADD/AND/NOT words, drives the
// ALU onto the bus, writes DR back and tracks the NZP condition codes.
module operate_sequencer #(
  parameter logic [2:0] NZP_RST  = 3'b010,
  parameter bit         ERR_HOLD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        abort,
  output logic [2:0]  ir_11_9,
  output logic [2:0]  ir_8_6,
  output logic [2:0]  ir_2_0,
  output logic        ir_5,
  output logic [4:0]  ir_4_0,
  output logic [1:0]  sr1mux,
  output logic [1:0]  drmux,
  output logic [1:0]  aluk,
  output logic        gate_alu,
  output logic        ld_reg,
  input  logic [15:0] alu_bus,
  output logic [2:0]  nzp,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [15:0] r_ir;
  logic [1:0]  r_aluk;
  logic [2:0]  r_nzp;
  logic        r_gate;
  logic        r_ld;
  logic        r_done;
  logic        r_illegal;
  logic        r_ready;

  logic [3:0]  w_in_op;
  logic [3:0]  w_ir_op;
  logic [1:0]  w_in_aluk;
  logic        w_ir_legal;
  logic [2:0]  w_nzp;

  assign w_in_op = instr[15:12];
  assign w_ir_op = r_ir[15:12];

  // aluk is decoded from the incoming word so it is stable through DECODE
  always_comb begin
    w_in_aluk = 2'b11;
    unique case (1'b1)
      (w_in_op == 4'b0001): w_in_aluk = 2'b00;
      (w_in_op == 4'b0101): w_in_aluk = 2'b01;
      (w_in_op == 4'b1001): w_in_aluk = 2'b10;
      default:              w_in_aluk = 2'b11;
    endcase
  end

  assign w_ir_legal = (w_ir_op == 4'b0001) ||
                      (w_ir_op == 4'b0101) ||
                      (w_ir_op == 4'b1001);

  always_comb begin
    w_nzp = 3'b001;
    unique case (1'b1)
      alu_bus[15]:         w_nzp = 3'b100;
      (alu_bus == 16'h0):  w_nzp = 3'b010;
      default:             w_nzp = 3'b001;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ir      <= 16'h0;
      r_aluk    <= 2'b11;
      r_nzp     <= NZP_RST;
      r_gate    <= 1'b0;
      r_ld      <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_gate    <= 1'b0;
      r_ld      <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_aluk  <= w_in_aluk;
            r_ready <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (abort) begin
            r_aluk  <= 2'b11;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_ir_legal) begin
            r_gate  <= 1'b1;
            r_ld    <= 1'b1;
            r_state <= S_EXEC;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_ERR;
          end
        end
        S_EXEC: begin
          r_nzp   <= w_nzp;
          r_aluk  <= 2'b11;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          if (!(ERR_HOLD && instr_valid)) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign ir_11_9     = r_ir[11:9];
  assign ir_8_6      = r_ir[8:6];
  assign ir_2_0      = r_ir[2:0];
  assign ir_5        = r_ir[5];
  assign ir_4_0      = r_ir[4:0];
  assign sr1mux      = 2'b01;
  assign drmux       = 2'b00;
  assign aluk        = r_aluk;
  assign gate_alu    = r_gate;
  assign ld_reg      = r_ld;
  assign nzp         = r_nzp;
  assign done        = r_done;
  assign illegal     = r_illegal;

endmodule
